// File: rtl/nx_fifo_mc_ram_1r1w_if.sv
// Push/pop request and status bundle for nx_fifo_mc_ram_1r1w.
// The master side issues pushes, pops and clears. The slave side is the FIFO.
interface nx_fifo_mc_ram_1r1w_if #(
    parameter int NUM_CH   = 4,
    parameter int CH_DEPTH = 16,
    parameter int WIDTH    = 64
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int UW = $clog2(CH_DEPTH + 1);

    logic                 wen;
    logic [CW-1:0]        wch;
    logic [WIDTH-1:0]     wdata;
    logic                 ren;
    logic [CW-1:0]        rch;
    logic [NUM_CH-1:0]    clear;
    logic                 rvalid;
    logic [WIDTH-1:0]     rdata;
    logic [CW-1:0]        rch_o;
    logic [NUM_CH-1:0]    empty;
    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    afull;
    logic [NUM_CH*UW-1:0] used_slots;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wen, wch, wdata, ren, rch, clear,
        input  rvalid, rdata, rch_o, empty, full, afull, used_slots, overflow, underflow
    );

    modport slave (
        input  wen, wch, wdata, ren, rch, clear,
        output rvalid, rdata, rch_o, empty, full, afull, used_slots, overflow, underflow
    );
endinterface

// File: rtl/nx_fifo_mc_ram_1r1w.sv
// Multi-channel FIFO: NUM_CH queues statically partitioned in one 1r1w RAM, with per-channel status and clear.
// Latency: a pop returns tagged data RD_LATENCY (1 or 2) cycles after it is accepted. Flags update one cycle after each op.
// Backpressure: none on the response. Requests to a full or empty channel are dropped and flagged with overflow or underflow.
module nx_fifo_mc_ram_1r1w #(
    parameter int NUM_CH     = 4,
    parameter int CH_DEPTH   = 16,
    parameter int WIDTH      = 64,
    parameter int AFULL_TH   = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nx_fifo_mc_ram_1r1w_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(CH_DEPTH);
    localparam int UW = $clog2(CH_DEPTH + 1);
    localparam int NW = NUM_CH * CH_DEPTH;
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [UW-1:0] cnt_t;

    ptr_t                 wptr_q [NUM_CH];
    ptr_t                 rptr_q [NUM_CH];
    ptr_t                 wptr_d [NUM_CH];
    ptr_t                 rptr_d [NUM_CH];
    cnt_t                 cnt_q  [NUM_CH];
    cnt_t                 cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]    empty_q;
    logic [NUM_CH-1:0]    full_q;
    logic [NUM_CH-1:0]    afull_q;
    logic [NUM_CH-1:0]    wsel;
    logic [NUM_CH-1:0]    rsel;
    logic [NUM_CH-1:0]    push_ch;
    logic [NUM_CH-1:0]    pop_ch;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 ovf_d;
    logic                 unf_d;
    logic                 ovf_q;
    logic                 unf_q;
    logic [AW-1:0]        waddr;
    logic [AW-1:0]        raddr;
    logic [WIDTH-1:0]     mem [NW];
    logic [WIDTH-1:0]     ram_q;
    logic                 rvld_q;
    logic [CW-1:0]        rch_q;
    logic [NUM_CH*UW-1:0] used_flat;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(CH_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Channel decode is one-hot so out-of-range channel numbers match nothing.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wsel[c] = (bus.wch == CW'(c));
            rsel[c] = (bus.rch == CW'(c));
        end
    end

    // Accepts are judged on registered pre-edge flags, never on same-cycle ops.
    assign push_ch = {NUM_CH{bus.wen}} & wsel & ~full_q  & ~bus.clear;
    assign pop_ch  = {NUM_CH{bus.ren}} & rsel & ~empty_q & ~bus.clear;
    assign ovf_d   = |({NUM_CH{bus.wen}} & wsel & full_q  & ~bus.clear);
    assign unf_d   = |({NUM_CH{bus.ren}} & rsel & empty_q & ~bus.clear);
    assign push_ok = |push_ch;
    assign pop_ok  = |pop_ch;

    always_comb begin
        waddr = '0;
        raddr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wsel[c]) waddr = AW'(c * CH_DEPTH) + AW'(wptr_q[c]);
            if (rsel[c]) raddr = AW'(c * CH_DEPTH) + AW'(rptr_q[c]);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if (bus.clear[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                cnt_d[c]  = '0;
            end else begin
                if (push_ch[c]) wptr_d[c] = ptr_inc(wptr_q[c]);
                if (pop_ch[c])  rptr_d[c] = ptr_inc(rptr_q[c]);
                cnt_d[c] = cnt_q[c] + cnt_t'(push_ch[c]) - cnt_t'(pop_ch[c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            empty_q <= '1;
            full_q  <= '0;
            afull_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c]  <= wptr_d[c];
                rptr_q[c]  <= rptr_d[c];
                cnt_q[c]   <= cnt_d[c];
                empty_q[c] <= (cnt_d[c] == '0);
                full_q[c]  <= (cnt_d[c] == cnt_t'(CH_DEPTH));
                afull_q[c] <= (cnt_d[c] >= cnt_t'(AFULL_TH));
            end
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            rvld_q <= pop_ok;
        end
    end

    // Storage and read register carry no reset; rdata/rch_o are only meaningful with rvalid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[waddr] <= bus.wdata;
        if (pop_ok) begin
            ram_q <= mem[raddr];
            rch_q <= bus.rch;
        end
    end

    generate
        if (RD_LATENCY >= 2) begin : g_lat2
            logic             rvld2_q;
            logic [WIDTH-1:0] rdata2_q;
            logic [CW-1:0]    rch2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rvld2_q <= 1'b0;
                else        rvld2_q <= rvld_q;
            end

            always_ff @(posedge clk) begin
                if (rvld_q) begin
                    rdata2_q <= ram_q;
                    rch2_q   <= rch_q;
                end
            end

            assign bus.rvalid = rvld2_q;
            assign bus.rdata  = rdata2_q;
            assign bus.rch_o  = rch2_q;
        end else begin : g_lat1
            assign bus.rvalid = rvld_q;
            assign bus.rdata  = ram_q;
            assign bus.rch_o  = rch_q;
        end
    endgenerate

    always_comb begin
        used_flat = '0;
        for (int c = 0; c < NUM_CH; c++) used_flat[c*UW +: UW] = cnt_q[c];
    end

    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
    assign bus.afull      = afull_q;
    assign bus.used_slots = used_flat;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;

    // A pop needs a non-empty channel and a push a non-full one, so the two ports never share an address.
    a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_ok && pop_ok && (waddr == raddr)));
    a_single_op: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(push_ch) && $onehot0(pop_ch));
endmodule

// File: tb/tb_nx_fifo_mc_ram_1r1w.sv
// Drives one RD_LATENCY=1 and one RD_LATENCY=2 instance with identical stimulus against a queue-per-channel model.
module tb_nx_fifo_mc_ram_1r1w;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int WIDTH  = 64;
    localparam int AFULL  = 12;
    localparam int CW     = 2;
    localparam int UW     = 5;

    logic              clk;
    logic              rst_n;
    logic              wen;
    logic [CW-1:0]     wch;
    logic [WIDTH-1:0]  wdata;
    logic              ren;
    logic [CW-1:0]     rch;
    logic [NUM_CH-1:0] clear;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [NUM_CH][$];
    bit               exp_rv, exp_rv2, exp_ovf, exp_unf;
    logic [WIDTH-1:0] exp_rd, exp_rd2;
    logic [CW-1:0]    exp_rch, exp_rch2;

    nx_fifo_mc_ram_1r1w_if #(.NUM_CH(NUM_CH), .CH_DEPTH(DEPTH), .WIDTH(WIDTH)) ifa ();
    nx_fifo_mc_ram_1r1w_if #(.NUM_CH(NUM_CH), .CH_DEPTH(DEPTH), .WIDTH(WIDTH)) ifb ();

    assign ifa.wen = wen;   assign ifb.wen = wen;
    assign ifa.wch = wch;   assign ifb.wch = wch;
    assign ifa.wdata = wdata; assign ifb.wdata = wdata;
    assign ifa.ren = ren;   assign ifb.ren = ren;
    assign ifa.rch = rch;   assign ifb.rch = rch;
    assign ifa.clear = clear; assign ifb.clear = clear;

    nx_fifo_mc_ram_1r1w #(.NUM_CH(NUM_CH), .CH_DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_TH(AFULL), .RD_LATENCY(1))
        dut_l1 (.clk(clk), .rst_n(rst_n), .bus(ifa));
    nx_fifo_mc_ram_1r1w #(.NUM_CH(NUM_CH), .CH_DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_TH(AFULL), .RD_LATENCY(2))
        dut_l2 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [33:0] stat_a, stat_b;
    logic [66:0] resp_a, resp_b;
    assign stat_a = {ifa.empty, ifa.full, ifa.afull, ifa.used_slots, ifa.overflow, ifa.underflow};
    assign stat_b = {ifb.empty, ifb.full, ifb.afull, ifb.used_slots, ifb.overflow, ifb.underflow};
    assign resp_a = {ifa.rvalid, ifa.rvalid ? {ifa.rch_o, ifa.rdata} : 66'd0};
    assign resp_b = {ifb.rvalid, ifb.rvalid ? {ifb.rch_o, ifb.rdata} : 66'd0};

    function automatic logic [33:0] exp_stat();
        logic [3:0]  e, f, a;
        logic [19:0] u;
        for (int c = 0; c < NUM_CH; c++) begin
            e[c] = (mq[c].size() == 0);
            f[c] = (mq[c].size() == DEPTH);
            a[c] = (mq[c].size() >= AFULL);
            u[c*UW +: UW] = 5'(mq[c].size());
        end
        return {e, f, a, u, exp_ovf, exp_unf};
    endfunction

    function automatic logic [66:0] exp_resp1();
        return {exp_rv, exp_rv ? {exp_rch, exp_rd} : 66'd0};
    endfunction

    function automatic logic [66:0] exp_resp2();
        return {exp_rv2, exp_rv2 ? {exp_rch2, exp_rd2} : 66'd0};
    endfunction

    // One clock of stimulus; the model decides acceptance from the queue contents before the edge.
    task automatic cyc(input bit we, input int wc, input logic [WIDTH-1:0] wd,
                       input bit re, input int rc, input logic [NUM_CH-1:0] clr);
        bit w_ok, r_ok;
        wen = we; wch = CW'(wc); wdata = wd; ren = re; rch = CW'(rc); clear = clr;
        w_ok    = we && (mq[wc].size() < DEPTH) && !clr[wc];
        r_ok    = re && (mq[rc].size() > 0) && !clr[rc];
        exp_ovf = we && (mq[wc].size() == DEPTH) && !clr[wc];
        exp_unf = re && (mq[rc].size() == 0) && !clr[rc];
        exp_rv2 = exp_rv; exp_rd2 = exp_rd; exp_rch2 = exp_rch;
        @(posedge clk);
        #1;
        exp_rv  = r_ok;
        exp_rch = CW'(rc);
        if (r_ok) exp_rd = mq[rc].pop_front();
        if (w_ok) mq[wc].push_back(wd);
        for (int c = 0; c < NUM_CH; c++) if (clr[c]) mq[c].delete();
        wen = 1'b0; ren = 1'b0; clear = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({stat_a, resp_a[66], stat_b, resp_b[66]} !== {exp_stat(), 1'b0, exp_stat(), 1'b0}) begin
            errors++;
            $display("FAIL in_reset: l1 %h/%b l2 %h/%b exp %h/0", stat_a, resp_a[66], stat_b, resp_b[66], exp_stat());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, '0, 0, 0, '0);
            checks++;
            if ({ifa.empty, ifa.full, ifa.used_slots, ifa.rvalid, ifb.empty, ifb.full, ifb.used_slots, ifb.rvalid}
                !== {4'hF, 4'h0, 20'h0, 1'b0, 4'hF, 4'h0, 20'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: l1 e=%h f=%h u=%h v=%b l2 e=%h f=%h u=%h v=%b exp e=f f=0 u=0 v=0",
                         i, ifa.empty, ifa.full, ifa.used_slots, ifa.rvalid, ifb.empty, ifb.full, ifb.used_slots, ifb.rvalid);
            end
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 35; i++) begin
            if (i < 16)       cyc(1, 2, 64'h100 + 64'(i), 0, 0, '0);
            else if (i == 16) cyc(1, 2, 64'h1ff, 0, 0, '0);
            else if (i == 17) cyc(1, 2, 64'h2ff, 1, 2, '0);
            else if (i < 33)  cyc(0, 0, '0, 1, 2, '0);
            else if (i == 33) cyc(0, 0, '0, 0, 0, '0);
            else              cyc(0, 0, '0, 1, 0, '0);
            checks++;
            if ({stat_a, stat_b} !== {exp_stat(), exp_stat()}) begin
                errors++; $display("FAIL fill_status cyc %0d: l1 %h l2 %h exp %h", i, stat_a, stat_b, exp_stat());
            end
            checks++;
            if ({resp_a, resp_b} !== {exp_resp1(), exp_resp2()}) begin
                errors++; $display("FAIL fill_resp cyc %0d: l1 %h l2 %h exp %h %h", i, resp_a, resp_b, exp_resp1(), exp_resp2());
            end
            if (i == 10 || i == 11) begin
                checks++;
                if (ifa.afull[2] !== (i == 11)) begin
                    errors++; $display("FAIL afull_th push %0d: got %b exp %b", i + 1, ifa.afull[2], (i == 11));
                end
            end
            if (i == 14 || i == 15) begin
                checks++;
                if (ifa.full[2] !== (i == 15)) begin
                    errors++; $display("FAIL full push %0d: got %b exp %b", i + 1, ifa.full[2], (i == 15));
                end
            end
            if (i == 16 || i == 17) begin
                checks++;
                if ({ifa.overflow, ifa.used_slots[2*UW +: UW]} !== {1'b1, (i == 16) ? 5'd16 : 5'd15}) begin
                    errors++; $display("FAIL overflow cyc %0d: got ovf=%b used=%0d exp ovf=1 used=%0d",
                                       i, ifa.overflow, ifa.used_slots[2*UW +: UW], (i == 16) ? 16 : 15);
                end
            end
            if (i >= 17 && i <= 32) begin
                checks++;
                if ({ifa.rvalid, ifa.rch_o, ifa.rdata} !== {1'b1, 2'd2, 64'h100 + 64'(i - 17)}) begin
                    errors++; $display("FAIL drain_order cyc %0d: got v=%b ch=%0d d=%h exp v=1 ch=2 d=%h",
                                       i, ifa.rvalid, ifa.rch_o, ifa.rdata, 64'h100 + 64'(i - 17));
                end
            end
            if (i == 34) begin
                checks++;
                if ({ifa.underflow, ifa.rvalid} !== 2'b10) begin
                    errors++; $display("FAIL underflow: got unf=%b v=%b exp unf=1 v=0", ifa.underflow, ifa.rvalid);
                end
            end
        end
    endtask

    task automatic test_interleave();
        int r, wc, rc;
        for (int i = 0; i < 200; i++) begin
            r  = int'($urandom_range(4, 0));
            wc = (r == 0) ? 0 : (r == 4) ? 3 : 1;
            r  = int'($urandom_range(3, 0));
            rc = (r == 0) ? 0 : (r == 3) ? 3 : 1;
            cyc(($urandom % 4) != 0, wc, {$urandom, $urandom}, ($urandom % 3) != 0, rc, '0);
            checks++;
            if ({stat_a, stat_b} !== {exp_stat(), exp_stat()}) begin
                errors++; $display("FAIL mix_status cyc %0d: l1 %h l2 %h exp %h", i, stat_a, stat_b, exp_stat());
            end
            checks++;
            if ({resp_a, resp_b} !== {exp_resp1(), exp_resp2()}) begin
                errors++; $display("FAIL mix_resp cyc %0d: l1 %h l2 %h exp %h %h", i, resp_a, resp_b, exp_resp1(), exp_resp2());
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 30; i++) begin
            if (i == 0)       cyc(0, 0, '0, 0, 0, 4'hF);
            else if (i < 6)   cyc(1, 3, 64'h300 + 64'(i - 1), 0, 0, '0);
            else if (i < 9)   cyc(1, 0, 64'h400 + 64'(i - 6), 0, 0, '0);
            else if (i == 9)  cyc(0, 0, '0, 1, 3, '0);
            else if (i == 10) cyc(1, 3, 64'hdead, 0, 0, 4'b1000);
            else if (i < 27)  cyc(1, 3, 64'h500 + 64'(i), 0, 0, '0);
            else if (i == 27) cyc(1, 3, 64'hbeef, 0, 0, 4'b1000);
            else if (i == 28) cyc(0, 0, '0, 1, 3, 4'b1000);
            else              cyc(0, 0, '0, 0, 0, '0);
            checks++;
            if ({stat_a, stat_b} !== {exp_stat(), exp_stat()}) begin
                errors++; $display("FAIL clear_status cyc %0d: l1 %h l2 %h exp %h", i, stat_a, stat_b, exp_stat());
            end
            checks++;
            if ({resp_a, resp_b} !== {exp_resp1(), exp_resp2()}) begin
                errors++; $display("FAIL clear_resp cyc %0d: l1 %h l2 %h exp %h %h", i, resp_a, resp_b, exp_resp1(), exp_resp2());
            end
            if (i == 10) begin
                checks++;
                if ({ifa.used_slots[3*UW +: UW], ifa.empty[3], ifa.overflow, ifa.used_slots[0 +: UW], ifb.rvalid, ifb.rdata}
                    !== {5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 64'h300}) begin
                    errors++;
                    $display("FAIL clear_ch3: got u3=%0d e3=%b ovf=%b u0=%0d inflight v=%b d=%h exp u3=0 e3=1 ovf=0 u0=3 v=1 d=300",
                             ifa.used_slots[3*UW +: UW], ifa.empty[3], ifa.overflow, ifa.used_slots[0 +: UW], ifb.rvalid, ifb.rdata);
                end
            end
            if (i == 26 || i == 27 || i == 28) begin
                checks++;
                if ({ifa.full[3], ifa.overflow, ifa.underflow} !== {(i == 26), 2'b00}) begin
                    errors++; $display("FAIL clear_full cyc %0d: got f3=%b ovf=%b unf=%b exp f3=%b ovf=0 unf=0",
                                       i, ifa.full[3], ifa.overflow, ifa.underflow, (i == 26));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 17; i++) begin
            if (i == 0)      cyc(0, 0, '0, 0, 0, 4'hF);
            else if (i < 5)  cyc(1, 1, 64'h1100 + 64'(i), 0, 0, '0);
            else if (i < 8)  cyc(1, 0, 64'h0a00 + 64'(i), 0, 0, '0);
            else if (i < 15) cyc(0, 0, '0, 1, (i < 12) ? 1 : 0, '0);
            else             cyc(0, 0, '0, 0, 0, '0);
            checks++;
            if ({stat_a, stat_b} !== {exp_stat(), exp_stat()}) begin
                errors++; $display("FAIL b2b_status cyc %0d: l1 %h l2 %h exp %h", i, stat_a, stat_b, exp_stat());
            end
            checks++;
            if ({resp_a, resp_b} !== {exp_resp1(), exp_resp2()}) begin
                errors++; $display("FAIL b2b_resp cyc %0d: l1 %h l2 %h exp %h %h", i, resp_a, resp_b, exp_resp1(), exp_resp2());
            end
            if (i >= 8) begin
                checks++;
                if ({ifb.rvalid, ifb.rvalid ? ifb.rch_o : 2'd0}
                    !== {(i >= 9 && i <= 15), (i >= 9 && i <= 15) ? ((i - 1 < 12) ? 2'd1 : 2'd0) : 2'd0}) begin
                    errors++; $display("FAIL b2b_lat2 cyc %0d: got v=%b ch=%0d exp v=%b", i, ifb.rvalid, ifb.rch_o, (i >= 9 && i <= 15));
                end
            end
        end
        cyc(1, 1, 64'h7001, 0, 0, '0);
        cyc(1, 1, 64'h7002, 0, 0, '0);
        cyc(0, 0, '0, 1, 1, '0);
        cyc(0, 0, '0, 1, 1, '0);
        checks++;
        if ({ifa.rvalid, ifb.rvalid, ifb.rdata} !== {1'b1, 1'b1, 64'h7001}) begin
            errors++; $display("FAIL pre_reset burst: got v1=%b v2=%b d2=%h exp 1 1 7001", ifa.rvalid, ifb.rvalid, ifb.rdata);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.rvalid, ifb.rvalid, ifa.empty, ifb.empty, ifa.used_slots, ifb.used_slots}
            !== {1'b0, 1'b0, 4'hF, 4'hF, 20'h0, 20'h0}) begin
            errors++; $display("FAIL async_reset: got v1=%b v2=%b e1=%h e2=%h u1=%h u2=%h exp 0 0 f f 0 0",
                               ifa.rvalid, ifb.rvalid, ifa.empty, ifb.empty, ifa.used_slots, ifb.used_slots);
        end
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        exp_rv = 1'b0; exp_rv2 = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, '0, 1, 1, '0);
        checks++;
        if ({stat_a, resp_a, stat_b, resp_b} !== {exp_stat(), exp_resp1(), exp_stat(), exp_resp2()}) begin
            errors++; $display("FAIL post_reset: l1 %h %h l2 %h %h exp %h", stat_a, resp_a, stat_b, resp_b, exp_stat());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wen = 1'b0; wch = '0; wdata = '0; ren = 1'b0; rch = '0; clear = '0;
        exp_rv = 1'b0; exp_rv2 = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        exp_rd = '0; exp_rd2 = '0; exp_rch = '0; exp_rch2 = '0;
        test_reset();
        test_fill_drain();
        test_interleave();
        test_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
